// File: rtl/cci_txn_tracker.sv
// CCI transaction tracker: snoops request/response channels, tracks outstanding
// mdata tags per channel, accumulates latency statistics and raises sticky
// protocol-anomaly flags (duplicate tag, orphan response, timeout).
module cci_txn_tracker #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned TAG_WIDTH      = 5,
  parameter int unsigned TS_WIDTH       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                              clk,
  input  logic                              sys_reset,
  input  logic                              enable,
  input  logic                              clear,
  input  logic [NUM_CH-1:0]                 req_valid,
  input  logic [NUM_CH*TAG_WIDTH-1:0]       req_tag,
  input  logic [NUM_CH-1:0]                 rsp_valid,
  input  logic [NUM_CH*TAG_WIDTH-1:0]       rsp_tag,
  output logic [NUM_CH*(TAG_WIDTH+1)-1:0]   outstanding,
  output logic [NUM_CH*CNT_WIDTH-1:0]       req_count,
  output logic [NUM_CH*CNT_WIDTH-1:0]       rsp_count,
  output logic [NUM_CH*CNT_WIDTH-1:0]       lat_sum,
  output logic [NUM_CH*TS_WIDTH-1:0]        lat_max,
  output logic [NUM_CH-1:0]                 err_dup,
  output logic [NUM_CH-1:0]                 err_orphan,
  output logic [NUM_CH-1:0]                 err_timeout,
  output logic [NUM_CH*TAG_WIDTH-1:0]       first_err_tag
);

  localparam int unsigned NSLOT = 1 << TAG_WIDTH;
  // Latency sum is formed one bit wider than the wider operand to catch overflow.
  localparam int unsigned SW    = ((CNT_WIDTH > TS_WIDTH) ? CNT_WIDTH : TS_WIDTH) + 1;
  localparam logic [TS_WIDTH-1:0]  TO_TS    = TS_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [SW-1:0]        SUM_MAX  = {{(SW-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

  logic [TS_WIDTH-1:0] r_now;

  // Free-running timestamp, cleared only by reset.
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) r_now <= '0;
    else           r_now <= r_now + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [NSLOT-1:0]     r_pending;
    logic [TS_WIDTH-1:0]  r_ts [NSLOT];
    logic [TAG_WIDTH-1:0] r_scan;
    logic                 r_fe_cap;
    logic [TAG_WIDTH-1:0] r_fe_tag;
    logic [TAG_WIDTH:0]   r_out;
    logic [CNT_WIDTH-1:0] r_req_cnt;
    logic [CNT_WIDTH-1:0] r_rsp_cnt;
    logic [CNT_WIDTH-1:0] r_lat_sum;
    logic [TS_WIDTH-1:0]  r_lat_max;
    logic                 r_err_dup;
    logic                 r_err_orp;
    logic                 r_err_to;

    logic [TAG_WIDTH-1:0] w_rt;
    logic [TAG_WIDTH-1:0] w_qt;
    logic                 w_rsp_hit;
    logic                 w_orphan;
    logic                 w_req;
    logic                 w_req_pend;
    logic                 w_dup;
    logic                 w_req_acc;
    logic [TS_WIDTH-1:0]  w_lat;
    logic [SW-1:0]        w_sum;
    logic                 w_scan_rsp;
    logic                 w_scan_req;
    logic                 w_scan_pend;
    logic [TS_WIDTH-1:0]  w_scan_ts;
    logic [TS_WIDTH-1:0]  w_age;
    logic                 w_to;
    logic                 w_any_err;
    logic [TAG_WIDTH-1:0] w_err_tag;

    // Decode this cycle's events in order: response, then request, then scan.
    always_comb begin
      w_rt       = rsp_tag[g*TAG_WIDTH +: TAG_WIDTH];
      w_qt       = req_tag[g*TAG_WIDTH +: TAG_WIDTH];
      w_rsp_hit  = enable & rsp_valid[g] & r_pending[w_rt];
      w_orphan   = enable & rsp_valid[g] & ~r_pending[w_rt];
      w_req      = enable & req_valid[g];
      // A same-cycle matched response frees the slot for legal reuse.
      w_req_pend = r_pending[w_qt] & ~(w_rsp_hit & (w_rt == w_qt));
      w_dup      = w_req & w_req_pend;
      w_req_acc  = w_req & ~w_req_pend;
      w_lat      = r_now - r_ts[w_rt];
      w_sum      = {{(SW-CNT_WIDTH){1'b0}}, r_lat_sum} + {{(SW-TS_WIDTH){1'b0}}, w_lat};
      // Scan sees the slot as it stands after this cycle's response and request.
      w_scan_rsp  = w_rsp_hit & (w_rt == r_scan);
      w_scan_req  = w_req_acc & (w_qt == r_scan);
      w_scan_pend = (r_pending[r_scan] & ~w_scan_rsp) | w_scan_req;
      w_scan_ts   = w_scan_req ? r_now : r_ts[r_scan];
      w_age       = r_now - w_scan_ts;
      w_to        = enable & w_scan_pend & (w_age >= TO_TS);
      w_any_err   = w_orphan | w_dup | w_to;
      w_err_tag   = w_orphan ? w_rt : (w_dup ? w_qt : r_scan);
    end

    // Issue timestamps; only read while the slot is pending, so no reset needed.
    always_ff @(posedge clk) begin
      if (w_req_acc) r_ts[w_qt] <= r_now;
    end

    // Outstanding-tag tracking and scan pointer; untouched by clear.
    always_ff @(posedge clk or posedge sys_reset) begin
      if (sys_reset) begin
        r_pending <= '0;
        r_scan    <= '0;
        r_out     <= '0;
      end else begin
        if (w_rsp_hit) r_pending[w_rt] <= 1'b0;
        if (w_req_acc) r_pending[w_qt] <= 1'b1;
        if (enable)    r_scan <= r_scan + 1'b1;
        case ({w_req_acc, w_rsp_hit})
          2'b10:   r_out <= r_out + 1'b1;
          2'b01:   r_out <= r_out - 1'b1;
          default: r_out <= r_out;
        endcase
      end
    end

    // Statistics and sticky errors; clear wins over same-cycle events.
    always_ff @(posedge clk or posedge sys_reset) begin
      if (sys_reset) begin
        r_req_cnt <= '0;
        r_rsp_cnt <= '0;
        r_lat_sum <= '0;
        r_lat_max <= '0;
        r_err_dup <= 1'b0;
        r_err_orp <= 1'b0;
        r_err_to  <= 1'b0;
        r_fe_cap  <= 1'b0;
        r_fe_tag  <= '0;
      end else if (clear) begin
        r_req_cnt <= '0;
        r_rsp_cnt <= '0;
        r_lat_sum <= '0;
        r_lat_max <= '0;
        r_err_dup <= 1'b0;
        r_err_orp <= 1'b0;
        r_err_to  <= 1'b0;
        r_fe_cap  <= 1'b0;
        r_fe_tag  <= '0;
      end else begin
        if (w_req && (r_req_cnt != CNT_MAX)) r_req_cnt <= r_req_cnt + 1'b1;
        if (w_rsp_hit) begin
          if (r_rsp_cnt != CNT_MAX) r_rsp_cnt <= r_rsp_cnt + 1'b1;
          if (w_sum > SUM_MAX) r_lat_sum <= CNT_MAX;
          else                 r_lat_sum <= w_sum[CNT_WIDTH-1:0];
          if (w_lat > r_lat_max) r_lat_max <= w_lat;
        end
        if (w_orphan) r_err_orp <= 1'b1;
        if (w_dup)    r_err_dup <= 1'b1;
        if (w_to)     r_err_to  <= 1'b1;
        if (w_any_err && !r_fe_cap) begin
          r_fe_cap <= 1'b1;
          r_fe_tag <= w_err_tag;
        end
      end
    end

    assign outstanding[g*(TAG_WIDTH+1) +: TAG_WIDTH+1] = r_out;
    assign req_count[g*CNT_WIDTH +: CNT_WIDTH]         = r_req_cnt;
    assign rsp_count[g*CNT_WIDTH +: CNT_WIDTH]         = r_rsp_cnt;
    assign lat_sum[g*CNT_WIDTH +: CNT_WIDTH]           = r_lat_sum;
    assign lat_max[g*TS_WIDTH +: TS_WIDTH]             = r_lat_max;
    assign err_dup[g]                                  = r_err_dup;
    assign err_orphan[g]                               = r_err_orp;
    assign err_timeout[g]                              = r_err_to;
    assign first_err_tag[g*TAG_WIDTH +: TAG_WIDTH]     = r_fe_tag;
  end

endmodule
